// File: rtl/seg7_pkg.sv
// seg7_pkg: shared definitions for the seven-segment capture path.
//   SEG_TABLE  - active-low {CA..CG} patterns for hex digits 0..F
//                (same table the display encoder uses)
//   err_code_t - error classification reported on err_code
//   state_t    - digit-settling FSM states
package seg7_pkg;

    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
        7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38
    };

    typedef enum logic [1:0] {
        ERR_NONE    = 2'b00,
        ERR_SEG     = 2'b01,
        ERR_MULTI   = 2'b10,
        ERR_TIMEOUT = 2'b11
    } err_code_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_HOLD
    } state_t;

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: combinational reverse lookup of an active-low segment pattern.
//   i_seg    - {CA,CB,CC,CD,CE,CF,CG}, active-low
//   o_hit    - pattern is one of the 16 hex glyphs
//   o_nibble - decoded hex value (0 when o_hit is low)
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [6:0] i_seg,
    output logic       o_hit,
    output logic [3:0] o_nibble
);

    // Table entries are unique, so at most one iteration matches.
    always_comb begin
        o_hit    = 1'b0;
        o_nibble = '0;
        for (int unsigned k = 0; k < 16; k++) begin
            if (i_seg == SEG_TABLE[k]) begin
                o_hit    = 1'b1;
                o_nibble = 4'(k);
            end
        end
    end

endmodule

// File: rtl/seg7_capture.sv
// seg7_capture: reads an eight-digit multiplexed seven-segment bus back into
// a 32-bit word.
//   ck, reset     - clock, synchronous active-high reset
//   an[7:0]       - active-low anodes, bit i selects digit i
//   seg[6:0]      - active-low {CA..CG}, CA is bit 6
//   digits[31:0]  - last complete frame, digit i in [4i+3:4i]
//   frame_valid   - one-cycle pulse when digits updates
//   frame_changed - one-cycle pulse with frame_valid when the word differs
//                   from the previous frame (or is the first since reset)
//   err           - one-cycle error pulse
//   err_code[1:0] - 01 bad pattern, 10 multiple anodes, 11 timeout (held)
// Build option: define SEG7_CAPTURE_CHANGE_EN to enable frame_changed;
// otherwise frame_changed is tied low.
module seg7_capture
    import seg7_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES  = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic        ck,
    input  logic        reset,
    input  logic [7:0]  an,
    input  logic [6:0]  seg,
    output logic [31:0] digits,
    output logic        frame_valid,
    output logic        frame_changed,
    output logic        err,
    output logic [1:0]  err_code
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0] CNT_LAST = 8'(STABLE_CYCLES - 1);

    logic [14:0]   r_smp;
    logic [14:0]   r_prev;
    state_t        r_state;
    state_t        w_state_next;
    logic [7:0]    r_cnt;
    logic [7:0]    w_cnt_next;
    logic [7:0]    r_seen;
    logic [31:0]   r_shadow;
    logic [TW-1:0] r_tcnt;
    err_code_t     r_err_code;

    logic [7:0]  w_an;
    logic [7:0]  w_prev_an;
    logic [3:0]  w_low;
    logic [3:0]  w_prev_low;
    logic        w_one;
    logic        w_multi;
    logic        w_multi_edge;
    logic        w_same;
    logic [2:0]  w_idx;
    logic        w_accept;
    logic        w_hit;
    logic [3:0]  w_nibble;
    logic [7:0]  w_seen_acc;
    logic        w_complete;
    logic [31:0] w_merged;
    logic        w_timeout;

    assign w_an         = r_smp[14:7];
    assign w_prev_an    = r_prev[14:7];
    assign w_low        = 4'($countones(~w_an));
    assign w_prev_low   = 4'($countones(~w_prev_an));
    assign w_one        = (w_low == 4'd1);
    assign w_multi      = (w_low >= 4'd2);
    assign w_multi_edge = w_multi && (w_prev_low < 4'd2);
    assign w_same       = (r_smp == r_prev);

    always_comb begin
        w_idx = '0;
        for (int unsigned k = 0; k < 8; k++) begin
            if (!w_an[k]) w_idx = 3'(k);
        end
    end

    seg7_decode u_decode (
        .i_seg    (r_smp[6:0]),
        .o_hit    (w_hit),
        .o_nibble (w_nibble)
    );

    // HOLD only leaves on a change of the sampled bus, so a digit that stays
    // lit is accepted exactly once per appearance.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_accept     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_one) begin
                    w_state_next = ST_SETTLE;
                    w_cnt_next   = 8'd1;
                end
            end
            ST_SETTLE: begin
                if (w_same) begin
                    if (r_cnt == CNT_LAST) begin
                        w_accept     = 1'b1;
                        w_state_next = ST_HOLD;
                    end else begin
                        w_cnt_next = r_cnt + 8'd1;
                    end
                end else if (w_one) begin
                    w_cnt_next = 8'd1;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (!w_same) begin
                    if (w_one) begin
                        w_state_next = ST_SETTLE;
                        w_cnt_next   = 8'd1;
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_merged = r_shadow;
        w_merged[{w_idx, 2'b00} +: 4] = w_nibble;
    end

    assign w_seen_acc = r_seen | (8'd1 << w_idx);
    assign w_complete = w_accept && w_hit && (w_seen_acc == 8'hFF);
    assign w_timeout  = !w_accept && (r_tcnt == TLAST);

    // The sample registers reset to the idle (all-high) bus so a multi-anode
    // pattern present at release is still seen as a fresh entry.
    always_ff @(posedge ck) begin
        if (reset) begin
            r_smp       <= '1;
            r_prev      <= '1;
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_seen      <= '0;
            r_shadow    <= '0;
            r_tcnt      <= '0;
            r_err_code  <= ERR_NONE;
            digits      <= '0;
            frame_valid <= 1'b0;
            err         <= 1'b0;
        end else begin
            r_smp       <= {an, seg};
            r_prev      <= r_smp;
            r_state     <= w_state_next;
            r_cnt       <= w_cnt_next;
            frame_valid <= 1'b0;
            err         <= 1'b0;

            if (w_accept) r_tcnt <= '0;
            else if (r_tcnt != TMAX) r_tcnt <= r_tcnt + 1'b1;

            if (w_accept) begin
                if (w_hit) begin
                    r_shadow <= w_merged;
                    if (w_complete) begin
                        digits      <= w_merged;
                        frame_valid <= 1'b1;
                        r_seen      <= '0;
                    end else begin
                        r_seen <= w_seen_acc;
                    end
                end else begin
                    err        <= 1'b1;
                    r_err_code <= ERR_SEG;
                end
            end else if (w_timeout) begin
                r_seen     <= '0;
                err        <= 1'b1;
                r_err_code <= ERR_TIMEOUT;
            end else if (w_multi_edge) begin
                err        <= 1'b1;
                r_err_code <= ERR_MULTI;
            end
        end
    end

    assign err_code = r_err_code;

`ifdef SEG7_CAPTURE_CHANGE_EN
    // digits itself holds the previous frame; r_have marks that one exists.
    logic r_have;
    logic r_changed;

    always_ff @(posedge ck) begin
        if (reset) begin
            r_have    <= 1'b0;
            r_changed <= 1'b0;
        end else begin
            r_changed <= 1'b0;
            if (w_complete) begin
                r_changed <= !r_have || (w_merged != digits);
                r_have    <= 1'b1;
            end
        end
    end

    assign frame_changed = r_changed;
`else
    assign frame_changed = 1'b0;
`endif

endmodule

// File: tb/tb_seg7_capture.sv
module tb_seg7_capture;

    localparam int unsigned S = 4;
    localparam int unsigned T = 50;

    logic        ck = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  an = 8'hFF;
    logic [6:0]  seg = 7'h7F;
    logic [31:0] digits;
    logic        frame_valid;
    logic        frame_changed;
    logic        err;
    logic [1:0]  err_code;

    seg7_capture #(.STABLE_CYCLES(S), .TIMEOUT_CYCLES(T)) dut (
        .ck            (ck),
        .reset         (reset),
        .an            (an),
        .seg           (seg),
        .digits        (digits),
        .frame_valid   (frame_valid),
        .frame_changed (frame_changed),
        .err           (err),
        .err_code      (err_code)
    );

    always #5 ck = ~ck;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;

    logic [6:0] tab [16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                             7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};

    // per-cycle stimulus {reset, an, seg}
    logic [15:0] q [$];

    // reference model state
    logic [14:0] m_smp = '1;
    logic [14:0] m_prev = '1;
    int          m_run = 0;
    logic [3:0]  m_nib [8];
    bit          m_seen [8];
    int          m_tsince = 0;
    int          m_last_acc = 0;
    bit          m_have = 0;
    logic        exp_fv = 0, exp_fc = 0, exp_err = 0;
    logic [1:0]  exp_code = 0;
    logic [31:0] exp_digits = 0;

    // One clock edge: the model judges the sample captured on the previous
    // edge (the bus is registered once), then records the current pins.
    task automatic tick();
        logic [7:0]  a;
        logic [6:0]  s;
        logic [31:0] word;
        int lows, plows, pos, val, nseen;
        @(posedge ck);
        cyc++;
        exp_fv = 0; exp_fc = 0; exp_err = 0;
        if (reset) begin
            m_smp = '1; m_prev = '1; m_run = 0; m_tsince = 0; m_have = 0;
            for (int i = 0; i < 8; i++) begin m_nib[i] = 0; m_seen[i] = 0; end
            exp_digits = 0; exp_code = 0;
        end else begin
            a = m_smp[14:7];
            s = m_smp[6:0];
            lows  = $countones(~a);
            plows = $countones(~m_prev[14:7]);
            if (m_smp == m_prev) begin
                if (m_run < 1000) m_run++;
            end else begin
                m_run = 1;
            end
            if (lows == 1 && m_run == int'(S)) begin
                m_tsince = 0;
                m_last_acc = cyc;
                pos = 0;
                for (int i = 0; i < 8; i++) if (!a[i]) pos = i;
                val = -1;
                for (int v = 0; v < 16; v++) if (tab[v] == s) val = v;
                if (val < 0) begin
                    exp_err = 1; exp_code = 2'b01;
                end else begin
                    m_nib[pos] = 4'(val);
                    m_seen[pos] = 1;
                    nseen = 0;
                    for (int i = 0; i < 8; i++) nseen += int'(m_seen[i]);
                    if (nseen == 8) begin
                        word = 0;
                        for (int i = 0; i < 8; i++) word[4*i +: 4] = m_nib[i];
`ifdef SEG7_CAPTURE_CHANGE_EN
                        exp_fc = !m_have || (word != exp_digits);
`endif
                        m_have = 1;
                        exp_digits = word;
                        exp_fv = 1;
                        for (int i = 0; i < 8; i++) m_seen[i] = 0;
                    end
                end
            end else if (m_tsince < int'(T) && (m_tsince + 1) == int'(T)) begin
                m_tsince++;
                for (int i = 0; i < 8; i++) m_seen[i] = 0;
                exp_err = 1; exp_code = 2'b11;
            end else begin
                if (m_tsince < int'(T)) m_tsince++;
                if (lows >= 2 && plows < 2) begin
                    exp_err = 1; exp_code = 2'b10;
                end
            end
            m_prev = m_smp;
            m_smp = {an, seg};
        end
        #1;
    endtask

    task automatic push(input logic r, input logic [7:0] a, input logic [6:0] s, input int n);
        for (int i = 0; i < n; i++) q.push_back({r, a, s});
    endtask

    task automatic push_scan(input logic [31:0] w, input int first, input int last,
                             input int hmin, input int hmax, input int gapmax);
        logic [3:0] nib;
        for (int i = first; i <= last; i++) begin
            nib = w[4*i +: 4];
            push(1'b0, ~(8'd1 << i), tab[nib], int'($urandom_range(hmax, hmin)));
            if (gapmax > 0) push(1'b0, 8'hFF, 7'h7F, int'($urandom_range(gapmax, 0)));
        end
    endtask

    task automatic test_reset();
        push(1'b1, 8'hFF, 7'h7F, 3);
        foreach (q[k]) begin
            {reset, an, seg} = q[k];
            tick();
            n_checks++;
            if ({frame_valid, frame_changed, err, err_code, digits} !== 37'd0) begin
                n_fail++;
                $display("FAIL reset_state: got %h required 0",
                         {frame_valid, frame_changed, err, err_code, digits});
            end
        end
        q.delete();
        reset = 1'b0;
    endtask

    task automatic test_eight_display();
        int nfv = 0, nfc = 0, exp_nfc;
        logic [31:0] last = 0;
        push(1'b0, 8'hFF, 7'h7F, 4);
        push_scan(32'hE5D00814, 0, 7, S + 1, S + 5, 2);
        push_scan(32'hE5D00814, 0, 7, S + 1, S + 5, 2);
        push(1'b0, 8'hFF, 7'h7F, S + 2);
        foreach (q[k]) begin
            {reset, an, seg} = q[k];
            tick();
            n_checks++;
            if ({frame_valid, frame_changed, err, err_code, digits} !==
                {exp_fv, exp_fc, exp_err, exp_code, exp_digits}) begin
                n_fail++;
                $display("FAIL display_cycle %0d: got %b%b%b %b %h required %b%b%b %b %h", cyc,
                         frame_valid, frame_changed, err, err_code, digits,
                         exp_fv, exp_fc, exp_err, exp_code, exp_digits);
            end
            if (frame_valid === 1'b1) begin nfv++; last = digits; end
            if (frame_valid === 1'b1 && frame_changed === 1'b1) nfc++;
        end
        q.delete();
`ifdef SEG7_CAPTURE_CHANGE_EN
        exp_nfc = 1;
`else
        exp_nfc = 0;
`endif
        n_checks++;
        if (nfv != 2) begin n_fail++; $display("FAIL display_frames: got %0d required 2", nfv); end
        n_checks++;
        if (last !== 32'hE5D00814) begin n_fail++; $display("FAIL display_word: got %h required e5d00814", last); end
        n_checks++;
        if (nfc != exp_nfc) begin n_fail++; $display("FAIL display_changed: got %0d required %0d", nfc, exp_nfc); end
    endtask

    task automatic test_short_hold();
        int nfv = 0;
        push(1'b0, 8'hFF, 7'h7F, 3);
        push(1'b0, 8'hFE, 7'h4C, 3);
        push(1'b0, 8'hFF, 7'h7F, 8);
        foreach (q[k]) begin
            {reset, an, seg} = q[k];
            tick();
            n_checks++;
            if ({frame_valid, frame_changed, err, err_code, digits} !==
                {exp_fv, exp_fc, exp_err, exp_code, exp_digits}) begin
                n_fail++;
                $display("FAIL short_cycle %0d: got %b%b%b %b %h required %b%b%b %b %h", cyc,
                         frame_valid, frame_changed, err, err_code, digits,
                         exp_fv, exp_fc, exp_err, exp_code, exp_digits);
            end
            if (frame_valid === 1'b1) nfv++;
        end
        q.delete();
        n_checks++;
        if (nfv != 0) begin n_fail++; $display("FAIL short_frames: got %0d required 0", nfv); end
    endtask

    task automatic test_multi();
        int nmulti = 0, nfv = 0;
        push(1'b0, 8'hFF, 7'h7F, 3);
        push(1'b0, 8'hFC, 7'h01, 10);
        push(1'b0, 8'hFF, 7'h7F, 4);
        foreach (q[k]) begin
            {reset, an, seg} = q[k];
            tick();
            n_checks++;
            if ({frame_valid, frame_changed, err, err_code, digits} !==
                {exp_fv, exp_fc, exp_err, exp_code, exp_digits}) begin
                n_fail++;
                $display("FAIL multi_cycle %0d: got %b%b%b %b %h required %b%b%b %b %h", cyc,
                         frame_valid, frame_changed, err, err_code, digits,
                         exp_fv, exp_fc, exp_err, exp_code, exp_digits);
            end
            if (err === 1'b1 && err_code === 2'b10) nmulti++;
            if (frame_valid === 1'b1) nfv++;
        end
        q.delete();
        n_checks++;
        if (nmulti != 1) begin n_fail++; $display("FAIL multi_errs: got %0d required 1", nmulti); end
        n_checks++;
        if (nfv != 0) begin n_fail++; $display("FAIL multi_frames: got %0d required 0", nfv); end
    endtask

    task automatic test_bad_seg();
        int nbad = 0, nfv = 0;
        push(1'b0, 8'hFF, 7'h7F, 3);
        push(1'b0, 8'hFE, 7'h7F, 6);
        push(1'b0, 8'hFF, 7'h7F, 2);
        // digits 1..7 alone must not complete a frame since digit 0 was rejected
        push_scan($urandom, 1, 7, S + 1, S + 3, 1);
        push(1'b0, 8'hFF, 7'h7F, T + 10);
        foreach (q[k]) begin
            {reset, an, seg} = q[k];
            tick();
            n_checks++;
            if ({frame_valid, frame_changed, err, err_code, digits} !==
                {exp_fv, exp_fc, exp_err, exp_code, exp_digits}) begin
                n_fail++;
                $display("FAIL badseg_cycle %0d: got %b%b%b %b %h required %b%b%b %b %h", cyc,
                         frame_valid, frame_changed, err, err_code, digits,
                         exp_fv, exp_fc, exp_err, exp_code, exp_digits);
            end
            if (err === 1'b1 && err_code === 2'b01) nbad++;
            if (frame_valid === 1'b1) nfv++;
        end
        q.delete();
        n_checks++;
        if (nbad != 1) begin n_fail++; $display("FAIL badseg_errs: got %0d required 1", nbad); end
        n_checks++;
        if (nfv != 0) begin n_fail++; $display("FAIL badseg_frames: got %0d required 0", nfv); end
    endtask

    task automatic test_timeout();
        int nfv = 0, t_dut = -1, t_req = -2;
        logic [31:0] w = $urandom;
        logic [31:0] last = 0;
        push(1'b0, 8'hFF, 7'h7F, 2);
        push_scan($urandom, 0, 6, S + 1, S + 4, 2);
        push(1'b0, 8'hFF, 7'h7F, T + 10);
        push_scan(w, 0, 7, S + 1, S + 4, 2);
        push(1'b0, 8'hFF, 7'h7F, S + 2);
        foreach (q[k]) begin
            {reset, an, seg} = q[k];
            tick();
            n_checks++;
            if ({frame_valid, frame_changed, err, err_code, digits} !==
                {exp_fv, exp_fc, exp_err, exp_code, exp_digits}) begin
                n_fail++;
                $display("FAIL timeout_cycle %0d: got %b%b%b %b %h required %b%b%b %b %h", cyc,
                         frame_valid, frame_changed, err, err_code, digits,
                         exp_fv, exp_fc, exp_err, exp_code, exp_digits);
            end
            if (err === 1'b1 && err_code === 2'b11) begin t_dut = cyc; t_req = m_last_acc + int'(T); end
            if (frame_valid === 1'b1) begin nfv++; last = digits; end
        end
        q.delete();
        n_checks++;
        if (t_dut != t_req) begin n_fail++; $display("FAIL timeout_when: got cycle %0d required %0d", t_dut, t_req); end
        n_checks++;
        if (nfv != 1) begin n_fail++; $display("FAIL timeout_frames: got %0d required 1", nfv); end
        n_checks++;
        if (last !== w) begin n_fail++; $display("FAIL timeout_word: got %h required %h", last, w); end
    endtask

    task automatic test_reset_mid();
        int nfv = 0;
        logic [31:0] w = $urandom;
        logic [31:0] last = 0;
        push(1'b0, 8'hFF, 7'h7F, 2);
        push_scan($urandom, 0, 4, S + 1, S + 4, 1);
        push(1'b1, 8'hFF, 7'h7F, 2);
        push_scan(w, 0, 7, S + 1, S + 4, 1);
        push(1'b0, 8'hFF, 7'h7F, S + 2);
        foreach (q[k]) begin
            {reset, an, seg} = q[k];
            tick();
            n_checks++;
            if ({frame_valid, frame_changed, err, err_code, digits} !==
                {exp_fv, exp_fc, exp_err, exp_code, exp_digits}) begin
                n_fail++;
                $display("FAIL rstmid_cycle %0d: got %b%b%b %b %h required %b%b%b %b %h", cyc,
                         frame_valid, frame_changed, err, err_code, digits,
                         exp_fv, exp_fc, exp_err, exp_code, exp_digits);
            end
            if (frame_valid === 1'b1) begin nfv++; last = digits; end
        end
        q.delete();
        n_checks++;
        if (nfv != 1) begin n_fail++; $display("FAIL rstmid_frames: got %0d required 1", nfv); end
        n_checks++;
        if (last !== w) begin n_fail++; $display("FAIL rstmid_word: got %h required %h", last, w); end
    endtask

    task automatic test_back_to_back();
        int nfv = 0;
        logic [31:0] w [3];
        logic [31:0] got [3];
        for (int j = 0; j < 3; j++) begin
            w[j] = $urandom;
            got[j] = 0;
            push_scan(w[j], 0, 7, S + 1, S + 1, 0);
        end
        push(1'b0, 8'hFF, 7'h7F, S + 2);
        foreach (q[k]) begin
            {reset, an, seg} = q[k];
            tick();
            n_checks++;
            if ({frame_valid, frame_changed, err, err_code, digits} !==
                {exp_fv, exp_fc, exp_err, exp_code, exp_digits}) begin
                n_fail++;
                $display("FAIL b2b_cycle %0d: got %b%b%b %b %h required %b%b%b %b %h", cyc,
                         frame_valid, frame_changed, err, err_code, digits,
                         exp_fv, exp_fc, exp_err, exp_code, exp_digits);
            end
            if (frame_valid === 1'b1) begin
                if (nfv < 3) got[nfv] = digits;
                nfv++;
            end
        end
        q.delete();
        n_checks++;
        if (nfv != 3) begin n_fail++; $display("FAIL b2b_frames: got %0d required 3", nfv); end
        for (int j = 0; j < 3; j++) begin
            n_checks++;
            if (got[j] !== w[j]) begin n_fail++; $display("FAIL b2b_word%0d: got %h required %h", j, got[j], w[j]); end
        end
    endtask

    task automatic test_random();
        int kind, i, j;
        logic [7:0] a;
        logic [6:0] s;
        for (int n = 0; n < 400; n++) begin
            kind = int'($urandom_range(9, 0));
            i = int'($urandom_range(7, 0));
            j = int'($urandom_range(7, 0));
            if (kind < 6) begin
                a = ~(8'd1 << i); s = tab[4'($urandom_range(15, 0))];
            end else if (kind == 6) begin
                a = ~(8'd1 << i); s = 7'($urandom);
            end else if (kind == 7) begin
                a = ~((8'd1 << i) | (8'd1 << ((i + 1 + (j % 7)) % 8))); s = 7'($urandom);
            end else begin
                a = 8'hFF; s = 7'($urandom);
            end
            push(1'b0, a, s, int'($urandom_range(S + 4, 1)));
        end
        push(1'b0, 8'hFF, 7'h7F, S + 2);
        foreach (q[k]) begin
            {reset, an, seg} = q[k];
            tick();
            n_checks++;
            if ({frame_valid, frame_changed, err, err_code, digits} !==
                {exp_fv, exp_fc, exp_err, exp_code, exp_digits}) begin
                n_fail++;
                $display("FAIL random_cycle %0d: got %b%b%b %b %h required %b%b%b %b %h", cyc,
                         frame_valid, frame_changed, err, err_code, digits,
                         exp_fv, exp_fc, exp_err, exp_code, exp_digits);
            end
        end
        q.delete();
    endtask

    initial begin
        test_reset();
        test_eight_display();
        test_short_hold();
        test_multi();
        test_bad_seg();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
